// File: rtl/cfg_write_arbiter_pkg.sv
// Shared register map, widths and FSM encodings for the PWM/output config block.
// Latency: n/a (constants and types only).
// Backpressure: n/a. The SPI frame decoder uses the same address constants.
package cfg_write_arbiter_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;

  localparam logic [ADDR_W-1:0] REG_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] REG_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] REG_DUTY   = 7'h04;
  localparam logic [ADDR_W-1:0] REG_LAST   = REG_DUTY;

  // Requester identity as stored in the round-robin history bit.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cfg_write_arbiter_if.sv
// Register-write request channel: one requester drives valid/addr/data, the arbiter returns ready.
// Latency: transfer completes on the edge where valid & ready are both high.
// Backpressure: requester holds addr/data stable while valid=1 and ready=0; valid never waits on ready.
interface cfg_write_arbiter_if;
  import cfg_write_arbiter_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; owns the last-grant history bit.
// Latency: gnt is combinational from req in the same cycle; history updates on the granting edge.
// Backpressure: at most one gnt bit set; on a tie the requester not granted last time wins.
// Ports: clock, rst (sync active-high), req[1:0] (bit0=A, bit1=B), gnt[1:0] one-hot.
module rr_arb2
  import cfg_write_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GRANT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to B so that A wins the first tie after reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      last_grant <= GRANT_B;
    end else if (|gnt) begin
      last_grant <= gnt[1] ? GRANT_B : GRANT_A;
    end
  end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Owns the 5-byte PWM/output config registers: loads defaults after reset, then arbitrates two writers.
// Latency: an accepted write is visible one cycle after the transfer edge; addr_err pulses in that cycle.
// Backpressure: ready is low during init and reset; otherwise one write accepted per cycle, round-robin.
// Ports: clock, rst (sync active-high), a_port/b_port (write channels, A = SPI decoder, B = test/boot host),
//        init_busy, addr_err, and the five register outputs.
module cfg_write_arbiter
  import cfg_write_arbiter_pkg::*;
#(
  parameter logic [7:0] DEF_OUT_LO = 8'h00,
  parameter logic [7:0] DEF_OUT_HI = 8'h00,
  parameter logic [7:0] DEF_PWM_LO = 8'h00,
  parameter logic [7:0] DEF_PWM_HI = 8'h00,
  parameter logic [7:0] DEF_DUTY   = 8'h00
) (
  input  logic                clock,
  input  logic                rst,
  cfg_write_arbiter_if.slave  a_port,
  cfg_write_arbiter_if.slave  b_port,
  output logic                init_busy,
  output logic                addr_err,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle
);

  localparam logic [2:0] INIT_LAST = REG_LAST[2:0];

  state_t            state_q, state_d;
  logic [2:0]        init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              run;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] def_val;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_busy  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy  = 1'b1;
        init_cnt_d = init_cnt_q + 3'd1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------- Arbitration ----------------
  // Gating with rst drops any handshake offered in a reset cycle.
  assign run = (state_q == ST_RUN) && !rst;
  assign req = {b_port.valid & run, a_port.valid & run};

  rr_arb2 u_arb (
    .clock (clock),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_port.ready = gnt[0];
  assign b_port.ready = gnt[1];

  // ---------------- Write mux ----------------
  always_comb begin
    def_val = DEF_DUTY;
    case (init_cnt_q)
      3'd0:    def_val = DEF_OUT_LO;
      3'd1:    def_val = DEF_OUT_HI;
      3'd2:    def_val = DEF_PWM_LO;
      3'd3:    def_val = DEF_PWM_HI;
      default: def_val = DEF_DUTY;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = {4'b0000, init_cnt_q};
      wr_data = def_val;
    end else if (gnt[0]) begin
      wr_en   = 1'b1;
      wr_addr = a_port.addr;
      wr_data = a_port.data;
    end else if (gnt[1]) begin
      wr_en   = 1'b1;
      wr_addr = b_port.addr;
      wr_data = b_port.data;
    end
  end

  // ---------------- Register file and error flag ----------------
  // Out-of-range addresses match no entry, so they are accepted but change nothing.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          regs_q[i] <= wr_data;
        end
      end
      addr_err <= (|gnt) && (wr_addr > REG_LAST);
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
module tb_cfg_write_arbiter;

  logic       clock;
  logic       rst;
  logic       init_busy;
  logic       addr_err;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int pass_cnt  = 0;
  int check_cnt = 0;

  cfg_write_arbiter_if a_if ();
  cfg_write_arbiter_if b_if ();

  cfg_write_arbiter #(
    .DEF_OUT_LO (8'h11),
    .DEF_OUT_HI (8'h22),
    .DEF_PWM_LO (8'h33),
    .DEF_PWM_HI (8'h44),
    .DEF_DUTY   (8'h80)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .a_port          (a_if),
    .b_port          (b_if),
    .init_busy       (init_busy),
    .addr_err        (addr_err),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_ports();
    a_if.valid = 1'b0; a_if.addr = 7'h00; a_if.data = 8'h00;
    b_if.valid = 1'b0; b_if.addr = 7'h00; b_if.data = 8'h00;
  endtask

  // Registers are checked as one 40-bit word {reg0,reg1,reg2,reg3,reg4}.
  function automatic logic [39:0] regs_now();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  // Releases reset at a negedge and walks through the five init cycles.
  task automatic run_init(input string tag);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_cnt++;
      if (init_busy !== 1'b1 || a_if.ready !== 1'b0 || b_if.ready !== 1'b0)
        $display("FAIL %s_busy cyc%0d: busy=%b a_rdy=%b b_rdy=%b, need busy=1 rdy=0",
                 tag, i + 1, init_busy, a_if.ready, b_if.ready);
      else pass_cnt++;
      @(negedge clock);
    end
    check_cnt++;
    if (init_busy !== 1'b0)
      $display("FAIL %s_done: init_busy=%b, need 0", tag, init_busy);
    else pass_cnt++;
    check_cnt++;
    if (regs_now() !== 40'h11_22_33_44_80)
      $display("FAIL %s_defaults: regs=%h, need 1122334480", tag, regs_now());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    idle_ports();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    check_cnt++;
    if (regs_now() !== 40'h0 || addr_err !== 1'b0 || init_busy !== 1'b1)
      $display("FAIL reset_state: regs=%h addr_err=%b busy=%b, need 0/0/1",
               regs_now(), addr_err, init_busy);
    else pass_cnt++;
    run_init("init");
  endtask

  task automatic test_a_only();
    a_if.valid = 1'b1; a_if.addr = 7'h04; a_if.data = 8'hA5;
    #1;
    check_cnt++;
    if (a_if.ready !== 1'b1 || b_if.ready !== 1'b0)
      $display("FAIL a_only_ready: a=%b b=%b, need 1/0", a_if.ready, b_if.ready);
    else pass_cnt++;
    @(negedge clock);
    idle_ports();
    check_cnt++;
    if (pwm_duty_cycle !== 8'hA5 || addr_err !== 1'b0)
      $display("FAIL a_only_write: duty=%h addr_err=%b, need a5/0", pwm_duty_cycle, addr_err);
    else pass_cnt++;
    @(negedge clock);
    check_cnt++;
    if (addr_err !== 1'b0 || regs_now() !== 40'h11_22_33_44_A5)
      $display("FAIL a_only_hold: regs=%h addr_err=%b, need 11223344a5/0", regs_now(), addr_err);
    else pass_cnt++;
  endtask

  task automatic test_addr_err();
    b_if.valid = 1'b1; b_if.addr = 7'h7F; b_if.data = 8'hFF;
    #1;
    check_cnt++;
    if (b_if.ready !== 1'b1 || a_if.ready !== 1'b0)
      $display("FAIL bad_addr_ready: b=%b a=%b, need 1/0", b_if.ready, a_if.ready);
    else pass_cnt++;
    @(negedge clock);
    idle_ports();
    check_cnt++;
    if (addr_err !== 1'b1 || regs_now() !== 40'h11_22_33_44_A5)
      $display("FAIL bad_addr_pulse: addr_err=%b regs=%h, need 1/11223344a5", addr_err, regs_now());
    else pass_cnt++;
    @(negedge clock);
    check_cnt++;
    if (addr_err !== 1'b0)
      $display("FAIL bad_addr_clear: addr_err=%b, need 0", addr_err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] a_addr [2];
    logic [7:0] a_data [2];
    logic [6:0] b_addr [2];
    logic [7:0] b_data [2];
    int ai;
    int bi;
    a_addr[0] = 7'h00; a_data[0] = 8'h01; a_addr[1] = 7'h01; a_data[1] = 8'h02;
    b_addr[0] = 7'h02; b_data[0] = 8'h03; b_addr[1] = 7'h03; b_data[1] = 8'h04;
    ai = 0;
    bi = 0;
    for (int k = 0; k < 4; k++) begin
      a_if.valid = (ai < 2);
      if (ai < 2) begin a_if.addr = a_addr[ai]; a_if.data = a_data[ai]; end
      b_if.valid = (bi < 2);
      if (bi < 2) begin b_if.addr = b_addr[bi]; b_if.data = b_data[bi]; end
      #1;
      check_cnt++;
      // Hand-derived order with last grant = B going in: A, B, A, B.
      if (a_if.ready !== ((k % 2) == 0) || b_if.ready !== ((k % 2) == 1))
        $display("FAIL rr_grant cyc%0d: a=%b b=%b, need %s", k, a_if.ready, b_if.ready,
                 ((k % 2) == 0) ? "A" : "B");
      else pass_cnt++;
      if (a_if.ready === 1'b1) ai++;
      if (b_if.ready === 1'b1) bi++;
      @(negedge clock);
    end
    idle_ports();
    check_cnt++;
    if (regs_now() !== 40'h01_02_03_04_A5)
      $display("FAIL rr_regs: regs=%h, need 01020304a5", regs_now());
    else pass_cnt++;
  endtask

  task automatic test_same_addr();
    a_if.valid = 1'b1; a_if.addr = 7'h00; a_if.data = 8'hAA;
    b_if.valid = 1'b1; b_if.addr = 7'h00; b_if.data = 8'hBB;
    #1;
    check_cnt++;
    if (a_if.ready !== 1'b1 || b_if.ready !== 1'b0)
      $display("FAIL conflict_first: a=%b b=%b, need 1/0", a_if.ready, b_if.ready);
    else pass_cnt++;
    @(negedge clock);
    a_if.valid = 1'b0;
    #1;
    check_cnt++;
    if (en_reg_out_7_0 !== 8'hAA || b_if.ready !== 1'b1)
      $display("FAIL conflict_second: reg0=%h b_rdy=%b, need aa/1", en_reg_out_7_0, b_if.ready);
    else pass_cnt++;
    @(negedge clock);
    idle_ports();
    check_cnt++;
    if (en_reg_out_7_0 !== 8'hBB)
      $display("FAIL conflict_final: reg0=%h, need bb", en_reg_out_7_0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // Reset arrives together with a pending write: it must be refused and never applied.
    a_if.valid = 1'b1; a_if.addr = 7'h01; a_if.data = 8'h5A;
    rst = 1'b1;
    #1;
    check_cnt++;
    if (a_if.ready !== 1'b0)
      $display("FAIL rst_pending_ready: a_rdy=%b, need 0", a_if.ready);
    else pass_cnt++;
    @(negedge clock);
    idle_ports();
    check_cnt++;
    if (regs_now() !== 40'h0 || init_busy !== 1'b1)
      $display("FAIL rst_run_clear: regs=%h busy=%b, need 0/1", regs_now(), init_busy);
    else pass_cnt++;
    // Let two init cycles complete, then reset again mid-init.
    rst = 1'b0;
    repeat (2) @(negedge clock);
    check_cnt++;
    if (regs_now() !== 40'h11_22_00_00_00)
      $display("FAIL init_partial: regs=%h, need 1122000000", regs_now());
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clock);
    check_cnt++;
    if (regs_now() !== 40'h0 || init_busy !== 1'b1)
      $display("FAIL rst_init_clear: regs=%h busy=%b, need 0/1", regs_now(), init_busy);
    else pass_cnt++;
    run_init("reinit");
  endtask

  initial begin
    idle_ports();
    rst = 1'b1;
    @(negedge clock);
    test_reset();
    @(negedge clock);
    test_a_only();
    @(negedge clock);
    test_addr_err();
    @(negedge clock);
    test_back_to_back();
    @(negedge clock);
    test_same_addr();
    @(negedge clock);
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
